memory_stage: RTL
=================

Name: memory_stage

Overview:
- Pipeline M stage: consumes the M-stage control and data that the execute stage registers, and performs the data-memory access over a ready/valid bus that may take several cycles.
- Stalls the upstream pipeline while an access is pending.
- Owns the W pipeline register and drives the writeback result back to execute for forwarding and to the register file.

Parameters:
MEM_TIMEOUT, 16, max cycles dmem_req_o may stay high without dmem_ready_i before a timeout error (range 2..255)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
reg_write_m_i  in  1  M-stage register-write enable
mem_write_m_i  in  1  M-stage store
mem_to_reg_m_i  in  1  M-stage load (result from memory)
alu_out_m_i  in  32  effective address / ALU result
write_data_m_i  in  32  store data
write_reg_m_i  in  5  destination register
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write, 0 = read
dmem_addr_o  out  32  word address (byte address, bits[1:0]=0)
dmem_wdata_o  out  32  store data
dmem_rdata_i  in  32  load data, valid when dmem_ready_i=1
dmem_ready_i  in  1  access complete this cycle
stall_m_o  out  1  freeze F/D/E/M registers this cycle
reg_write_w_o  out  1  W-stage register-write enable
write_reg_w_o  out  5  W-stage destination
result_w_o  out  32  W-stage result
error_o  out  1  sticky bus error
error_cause_o  out  2  00 none, 01 timeout, 10 misaligned

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low; all state returns to reset values immediately on assertion.
- Reset values: FSM=IDLE; wait counter=0; W register all zero; error_o=0; error_cause_o=00. Outputs are therefore reset_w=0, result_w_o=0, dmem_req_o=0 (combinational from IDLE with no access).
- Access definition: access = (mem_write_m_i | mem_to_reg_m_i) & ~error_o. Misaligned = access & (alu_out_m_i[1:0] != 0).
- Request drive:
  - dmem_req_o = access & ~misaligned (combinational) in IDLE or WAIT.
  - dmem_we_o = mem_write_m_i.
  - dmem_addr_o = alu_out_m_i; dmem_wdata_o = write_data_m_i.
  - Inputs stay stable because upstream is stalled.
- Handshake: a transfer completes in any cycle with dmem_req_o & dmem_ready_i. Zero-wait memory (ready in the same cycle) costs no stall. dmem_req_o never drops before completion, except on timeout or reset.
- stall_m_o = dmem_req_o & ~dmem_ready_i & ~timeout_now.
- FSM states:
  - IDLE: go to WAIT if dmem_req_o & ~dmem_ready_i; counter=1.
  - WAIT:
    - On ready: go to IDLE, counter=0.
    - If counter == MEM_TIMEOUT-1 and no ready: timeout_now=1, go to ERROR, cause 01.
    - Otherwise counter++.
  - ERROR: absorbing until reset; error_o=1. Memory ops become NOPs: no request, no register write. Non-memory instructions continue normally.
- Misaligned access: no request, no stall; go to ERROR with cause 10 on that edge.
- Simultaneous events: ready in the same cycle as the timeout threshold means success (ready wins). Only the first error's cause is recorded.
- W register: loads on every edge.
  - When stall_m_o=0: captures reg_write (forced 0 on timeout or misaligned), mem_to_reg, read data (dmem_rdata_i on completion, else 0), alu_out_m_i, write_reg_m_i.
  - When stall_m_o=1: loads a bubble (reg_write=0, other fields 0).
- Result mux: result_w_o = mem_to_reg_w ? read_data_w : alu_out_w (combinational from the W register).
- Latency: load data appears on result_w_o one cycle after the completion cycle.
- Stores: a store with reg_write_m_i=1 still writes back alu_out (it is not suppressed); control normally keeps it 0.

Decomposition:
- Package mem_stage_pkg:
  - mem_state_e {IDLE, WAIT, ERROR}
  - err_cause_e {ERR_NONE=2'b00, ERR_TIMEOUT=2'b01, ERR_MISALIGN=2'b10}
  - Default MEM_TIMEOUT constant
- Sub-module writeback_reg: W pipeline register (control + read_data + alu_out + write_reg), async active-low reset, stall-to-bubble input.

Test Plan:
- Zero-wait load: addr 0x10, dmem_ready_i tied 1, rdata 0xDEADBEEF, write_reg 5 -> stall_m_o never high; next cycle reg_write_w_o=1, write_reg_w_o=5, result_w_o=0xDEADBEEF.
- Store with 3 wait cycles: mem_write=1, addr 0x20, wdata 0x1234, ready on 4th cycle -> req/we/addr/wdata stable 4 cycles; stall_m_o=1 for 3 cycles; W gets bubbles during the stall, then reg_write_w_o=0.
- Timeout with MEM_TIMEOUT=4 and ready never asserted -> stall for 3 cycles, req drops; error_o=1, error_cause_o=01; W reg_write=0; later loads issue no request.
- Ready on threshold cycle: ready asserted exactly at counter=MEM_TIMEOUT-1 -> normal completion, error_o stays 0.
- Misaligned load: addr 0x13 -> dmem_req_o=0, no stall; error_cause_o=10; W reg_write=0.
- Reset mid-WAIT: rst_ni low during a pending request -> dmem_req_o, stall_m_o and all W outputs go to 0 immediately; FSM=IDLE; a fresh load after release completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the M stage: FSM states, error causes and the W-register payload.
// No logic here beyond a small alignment helper.
package mem_stage_pkg;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERROR
    } mem_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_MISALIGN = 2'b10
    } err_cause_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
    } wb_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/memory_stage_writeback_reg.sv
// W pipeline register with result mux.
// Latency: one cycle, loads every edge.
// Backpressure: none of its own; bubble_i loads an all-zero (no-write) entry.
module writeback_reg
    import mem_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bubble_i,
    input  wb_t         wb_i,
    output logic        reg_write_o,
    output logic [4:0]  write_reg_o,
    output logic [31:0] result_o
);

    wb_t wb_d;
    wb_t wb_q;

    always_comb begin
        wb_d = wb_i;
        if (bubble_i) begin
            wb_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign reg_write_o = wb_q.reg_write;
    assign write_reg_o = wb_q.write_reg;
    assign result_o    = wb_q.mem_to_reg ? wb_q.read_data : wb_q.alu_out;

endmodule

// File: rtl/memory_stage.sv
// M stage: data-memory access over ready/valid, sticky error tracking, W register.
// Latency: zero-wait access costs no stall; result appears one cycle after completion.
// Backpressure: stall_m_o holds upstream while a request waits for dmem_ready_i.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_write_m_i,
    input  logic        mem_write_m_i,
    input  logic        mem_to_reg_m_i,
    input  logic [31:0] alu_out_m_i,
    input  logic [31:0] write_data_m_i,
    input  logic [4:0]  write_reg_m_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ready_i,
    output logic        stall_m_o,
    output logic        reg_write_w_o,
    output logic [4:0]  write_reg_w_o,
    output logic [31:0] result_w_o,
    output logic        error_o,
    output logic [1:0]  error_cause_o
);

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    mem_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    err_cause_e cause_q, cause_d;

    logic mem_op;
    logic access;
    logic misaligned;
    logic req;
    logic done;
    logic timeout_now;
    logic stall;
    logic kill_write;
    wb_t  wb_in;

    assign error_o       = (state_q == ERROR);
    assign error_cause_o = cause_q;

    // Gating with rst_ni drops the request the instant reset asserts, even
    // though the stalled upstream still presents the memory op.
    assign mem_op      = mem_write_m_i | mem_to_reg_m_i;
    assign access      = rst_ni & mem_op & ~error_o;
    assign misaligned  = access & is_misaligned(alu_out_m_i);
    assign req         = access & ~misaligned;
    assign done        = req & dmem_ready_i;
    assign timeout_now = (state_q == WAIT) & req & ~dmem_ready_i & (cnt_q == CNT_LAST);
    assign stall       = req & ~dmem_ready_i & ~timeout_now;

    assign dmem_req_o   = req;
    assign dmem_we_o    = mem_write_m_i;
    assign dmem_addr_o  = alu_out_m_i;
    assign dmem_wdata_o = write_data_m_i;
    assign stall_m_o    = stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    state_d = ERROR;
                    cause_d = ERR_MISALIGN;
                end else if (req && !dmem_ready_i) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end
            end
            WAIT: begin
                if (misaligned) begin
                    state_d = ERROR;
                    cause_d = ERR_MISALIGN;
                    cnt_d   = '0;
                end else if (!req || dmem_ready_i) begin
                    // Ready on the threshold cycle still counts as success.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (timeout_now) begin
                    state_d = ERROR;
                    cause_d = ERR_TIMEOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cause_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Failed or suppressed memory ops must never reach the register file.
    assign kill_write = timeout_now | misaligned | (error_o & mem_op);

    always_comb begin
        wb_in            = '0;
        wb_in.reg_write  = reg_write_m_i & ~kill_write;
        wb_in.mem_to_reg = mem_to_reg_m_i;
        wb_in.read_data  = done ? dmem_rdata_i : 32'd0;
        wb_in.alu_out    = alu_out_m_i;
        wb_in.write_reg  = write_reg_m_i;
    end

    writeback_reg u_writeback_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bubble_i    (stall),
        .wb_i        (wb_in),
        .reg_write_o (reg_write_w_o),
        .write_reg_o (write_reg_w_o),
        .result_o    (result_w_o)
    );

endmodule
